fpu_operand_unpack: RTL and testbench
=====================================

FPU_OPERAND_UNPACK -- requirements
Module: fpu_operand_unpack

Interface
REQ-001: The block SHALL have parameter FLUSH_SUBNORMAL, default 0; when 1, subnormal operands decode as signed zero.
REQ-002: The block SHALL have port clk_i, input, 1, system clock, all state on rising edge.
REQ-003: The block SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-004: The block SHALL have port in_valid_i, input, 1, operand pair present.
REQ-005: The block SHALL have port in_ready_o, output, 1, block can accept operand pair.
REQ-006: The block SHALL have port op_a_i and op_b_i, input, 32 each, raw IEEE-754 binary32 operands.
REQ-007: The block SHALL have port sub_op_i, input, 1, subtract request, carried with operands.
REQ-008: The block SHALL have port rounding_mode_i, input, 3, RNE/RTZ/RDN/RUP/RMM code, carried with operands.
REQ-009: The block SHALL have port out_valid_o, input-side pair decoded and held, output, 1.
REQ-010: The block SHALL have port out_ready_i, input, 1, consumer (adder stage) accepts.
REQ-011: The block SHALL have outputs sign_A_o/sign_B_o (1), exp_A_o/exp_B_o (8), sig_A_o/sig_B_o (24), isZeroA_o/isZeroB_o, isInfA_o/isInfB_o, isNaNA_o/isNaNB_o, isSignaling_o (1 each), sub_op_o (1), rounding_mode_o (3): decoded fields matching the add/sub core input set.

Function
REQ-012: Transfer SHALL occur on a cycle where valid and ready are both high, on the respective side.
REQ-013: Decoding SHALL be: sign = bit31; exp = bits30:23 unchanged; sig = {exp!=0, bits22:0}.
REQ-014: isZero SHALL be exp==0 and fraction==0; isInf SHALL be exp==8'hFF and fraction==0; isNaN SHALL be exp==8'hFF and fraction!=0.
REQ-015: isSignaling SHALL be (isNaNA and !op_a[22]) or (isNaNB and !op_b[22]).
REQ-016: With FLUSH_SUBNORMAL=1, exp==0 operands SHALL output sig=0 and isZero=1, sign preserved.
REQ-017: Decoding SHALL happen before registration; outputs SHALL come straight from storage registers (no combinational input-to-output path on data).
REQ-018: Latency SHALL be exactly 1 cycle: pair accepted at edge N appears with out_valid_o high after edge N when storage was empty.
REQ-019: Storage SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL; in_ready_o = (state != FULL), registered.
REQ-020: Transitions: EMPTY+push->ONE; ONE+push-only->FULL; ONE+pop-only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; FULL never pushes.
REQ-021: Order SHALL be preserved; out_valid_o = (state != EMPTY); output fields SHALL be stable while out_valid_o high and out_ready_i low.
REQ-022: Input pair presented while in_ready_o low SHALL be ignored, no state change.

Reset
REQ-023: reset_i low SHALL asynchronously force state EMPTY, out_valid_o=0, in_ready_o=1, all data outputs 0.
REQ-024: Reset mid-operation SHALL discard all held pairs; first pair after release SHALL be accepted on first edge with reset_i high.

Configuration
REQ-025: Macro FPU_UNPACK_SKID_EN SHALL, when defined, build the 2-entry skid buffer of REQ-019..020.
REQ-026: Without FPU_UNPACK_SKID_EN, storage SHALL be one register; in_ready_o = !out_valid_o or out_ready_i (combinational), throughput still one pair per cycle, latency 1.

Verification
REQ-027: op_a=32'h3F800000, op_b=32'hC0000000, sub_op=1 -> next cycle sign_A=0 exp_A=8'h7F sig_A=24'h800000, sign_B=1 exp_B=8'h80 sig_B=24'h800000, sub_op_o=1, no flags.
REQ-028: op_a=32'h00000001, FLUSH_SUBNORMAL=0 -> exp_A=0, sig_A=24'h000001, isZeroA=0; FLUSH_SUBNORMAL=1 -> sig_A=0, isZeroA=1.
REQ-029: op_a=32'h7F800001, op_b=32'hFF800000 -> isNaNA=1, isSignaling=1, isInfB=1, sign_B=1; op_a=32'h7FC00000 -> isSignaling=0.
REQ-030: out_ready_i low, push pairs P1,P2,P3 on consecutive cycles (skid enabled) -> P1,P2 accepted, in_ready_o low, P3 ignored; raise out_ready_i -> P1 then P2 in order, in_ready_o high after first pop.
REQ-031: Push and pop same cycle in state ONE continuously 10 cycles -> out_valid_o stays 1, 10 pairs emitted in order, no bubbles.
REQ-032: State FULL, assert reset_i low mid-cycle -> out_valid_o=0 and in_ready_o=1 immediately, no held pair emitted after release.

Source files
------------

// File: rtl/fpu_operand_unpack.sv
// fpu_operand_unpack
// Splits two raw binary32 operands into sign, exponent, significand and class
// flags for the add/sub core, then registers the decoded pair behind a
// valid/ready handshake. Outputs come straight from storage registers.
//
// Build option: define FPU_UNPACK_SKID_EN for a 2-entry skid buffer with a
// fully registered in_ready_o. Without it, a single output register is used
// and in_ready_o is combinational from out_ready_i.
module fpu_operand_unpack #(
    parameter bit FLUSH_SUBNORMAL = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        sub_op_i,
    input  logic [2:0]  rounding_mode_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        sign_A_o,
    output logic        sign_B_o,
    output logic [7:0]  exp_A_o,
    output logic [7:0]  exp_B_o,
    output logic [23:0] sig_A_o,
    output logic [23:0] sig_B_o,
    output logic        isZeroA_o,
    output logic        isZeroB_o,
    output logic        isInfA_o,
    output logic        isInfB_o,
    output logic        isNaNA_o,
    output logic        isNaNB_o,
    output logic        isSignaling_o,
    output logic        sub_op_o,
    output logic [2:0]  rounding_mode_o
);

    // Decoded word layout (MSB first): operand A fields, operand B fields,
    // zero/inf/nan flag pairs, signaling flag, sub_op, rounding mode.
    localparam int WORD_W = 77;

    logic [1:0][31:0] op_raw;
    logic [1:0]       dec_sign;
    logic [1:0][7:0]  dec_exp;
    logic [1:0][23:0] dec_sig;
    logic [1:0]       dec_zero;
    logic [1:0]       dec_inf;
    logic [1:0]       dec_nan;
    logic [1:0]       dec_snan;
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] head_reg;

    assign op_raw[0] = op_a_i;
    assign op_raw[1] = op_b_i;

    // Per-operand field extraction and classification, done before storage.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [7:0]  exp_w;
            logic [22:0] frac_w;
            logic        exp_zero_w;
            logic        exp_max_w;
            logic        frac_zero_w;

            assign exp_w       = op_raw[gi][30:23];
            assign frac_w      = op_raw[gi][22:0];
            assign exp_zero_w  = (exp_w == 8'h00);
            assign exp_max_w   = (exp_w == 8'hFF);
            assign frac_zero_w = (frac_w == 23'd0);

            assign dec_sign[gi] = op_raw[gi][31];
            assign dec_exp[gi]  = exp_w;
            // Flushed subnormals keep their sign but lose the fraction.
            assign dec_sig[gi]  = (FLUSH_SUBNORMAL && exp_zero_w) ? 24'd0
                                                                  : {!exp_zero_w, frac_w};
            assign dec_zero[gi] = exp_zero_w && (FLUSH_SUBNORMAL || frac_zero_w);
            assign dec_inf[gi]  = exp_max_w && frac_zero_w;
            assign dec_nan[gi]  = exp_max_w && !frac_zero_w;
            // Quiet bit clear on a NaN marks it signaling.
            assign dec_snan[gi] = dec_nan[gi] && !frac_w[22];
        end
    endgenerate

    assign in_word = {dec_sign[0], dec_exp[0], dec_sig[0],
                      dec_sign[1], dec_exp[1], dec_sig[1],
                      dec_zero[0], dec_zero[1],
                      dec_inf[0], dec_inf[1],
                      dec_nan[0], dec_nan[1],
                      |dec_snan, sub_op_i, rounding_mode_i};

    assign {sign_A_o, exp_A_o, sig_A_o,
            sign_B_o, exp_B_o, sig_B_o,
            isZeroA_o, isZeroB_o,
            isInfA_o, isInfB_o,
            isNaNA_o, isNaNB_o,
            isSignaling_o, sub_op_o, rounding_mode_o} = head_reg;

`ifdef FPU_UNPACK_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              in_ready_reg;
    logic [WORD_W-1:0] skid_reg;
    logic              push;
    logic              pop;
    logic              head_load;
    logic              head_from_skid;
    logic              skid_load;

    assign push        = in_valid_i && in_ready_reg;
    assign pop         = (state_reg != EMPTY) && out_ready_i;
    assign in_ready_o  = in_ready_reg;
    assign out_valid_o = (state_reg != EMPTY);

    // Next-state and register-load decisions for the two-entry buffer.
    always_comb begin
        state_next     = state_reg;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    head_load  = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_next = FULL;
                    skid_load  = 1'b1;
                end else if (!push && pop) begin
                    state_next = EMPTY;
                end else if (push && pop) begin
                    head_load  = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next     = ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // State register; ready is precomputed so it leaves a flop directly.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
        end
    end

    // Data storage: head drives the outputs, skid catches the overflow pair.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (head_load) begin
                head_reg <= in_word;
            end else if (head_from_skid) begin
                head_reg <= skid_reg;
            end
            if (skid_load) begin
                skid_reg <= in_word;
            end
        end
    end

`else

    logic valid_reg;
    logic push;

    assign in_ready_o  = !valid_reg || out_ready_i;
    assign out_valid_o = valid_reg;
    assign push        = in_valid_i && in_ready_o;

    // Single pipeline register; reloads on the same edge it drains.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_reg <= 1'b0;
            head_reg  <= '0;
        end else if (push) begin
            valid_reg <= 1'b1;
            head_reg  <= in_word;
        end else if (out_ready_i) begin
            valid_reg <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Testbench for fpu_operand_unpack. Two instances (flush off / flush on) share
// the same stimulus; a scoreboard queue per instance holds expected words
// computed by an arithmetic reference model.
module tb_fpu_operand_unpack;

`ifdef FPU_UNPACK_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        sub_op_i = 1'b0;
    logic [2:0]  rounding_mode_i = '0;
    logic        out_ready_i = 1'b0;

    logic [1:0]       in_ready, out_valid;
    logic [1:0]       sign_a, sign_b, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan, sub_o;
    logic [1:0][7:0]  exp_a, exp_b;
    logic [1:0][23:0] sig_a, sig_b;
    logic [1:0][2:0]  rm_o;
    logic [76:0]      out_vec [2];

    int tests = 0;
    int fails = 0;
    int emitted = 0;
    logic [76:0] exp_q [2][$];

    always #5 clk_i = ~clk_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            fpu_operand_unpack #(.FLUSH_SUBNORMAL(gi == 1)) dut (
                .clk_i(clk_i), .reset_i(reset_i),
                .in_valid_i(in_valid_i), .in_ready_o(in_ready[gi]),
                .op_a_i(op_a_i), .op_b_i(op_b_i),
                .sub_op_i(sub_op_i), .rounding_mode_i(rounding_mode_i),
                .out_valid_o(out_valid[gi]), .out_ready_i(out_ready_i),
                .sign_A_o(sign_a[gi]), .sign_B_o(sign_b[gi]),
                .exp_A_o(exp_a[gi]), .exp_B_o(exp_b[gi]),
                .sig_A_o(sig_a[gi]), .sig_B_o(sig_b[gi]),
                .isZeroA_o(zero_a[gi]), .isZeroB_o(zero_b[gi]),
                .isInfA_o(inf_a[gi]), .isInfB_o(inf_b[gi]),
                .isNaNA_o(nan_a[gi]), .isNaNB_o(nan_b[gi]),
                .isSignaling_o(snan[gi]), .sub_op_o(sub_o[gi]),
                .rounding_mode_o(rm_o[gi])
            );
            assign out_vec[gi] = {sign_a[gi], exp_a[gi], sig_a[gi],
                                  sign_b[gi], exp_b[gi], sig_b[gi],
                                  zero_a[gi], zero_b[gi], inf_a[gi], inf_b[gi],
                                  nan_a[gi], nan_b[gi], snan[gi], sub_o[gi], rm_o[gi]};
        end
    endgenerate

    task automatic check(input string name, input logic [76:0] act, input logic [76:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: classify each operand from its numeric fields.
    function automatic logic [76:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic [2:0] rm,
                                          input bit flush);
        logic [31:0] op [2];
        int unsigned e [2];
        int unsigned f [2];
        int unsigned sg [2];
        bit z [2];
        bit inf [2];
        bit nan [2];
        bit sn;
        op[0] = a;
        op[1] = b;
        sn = 0;
        for (int i = 0; i < 2; i++) begin
            e[i]   = (op[i] / 32'd8388608) % 256;
            f[i]   = op[i] % 32'd8388608;
            sg[i]  = (e[i] != 0) ? f[i] + 8388608 : f[i];
            z[i]   = (e[i] == 0) && (f[i] == 0);
            inf[i] = (e[i] == 255) && (f[i] == 0);
            nan[i] = (e[i] == 255) && (f[i] != 0);
            if (nan[i] && f[i] < 4194304) sn = 1;
            if (flush && e[i] == 0) begin
                sg[i] = 0;
                z[i]  = 1;
            end
        end
        return {op[0][31], 8'(e[0]), 24'(sg[0]), op[1][31], 8'(e[1]), 24'(sg[1]),
                z[0], z[1], inf[0], inf[1], nan[0], nan[1], sn, sub, rm};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] s;
        s = {$urandom_range(0, 1), 31'd0};
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return s;
            2: return s | 32'($urandom_range(1, 8388607));
            3: return s | 32'h7F800000;
            4: return s | 32'h7FC00000 | 32'($urandom_range(0, 4194303));
            default: return s | 32'h7F800000 | 32'($urandom_range(1, 4194303));
        endcase
    endfunction

    // Stimulus side of the scoreboard: record every accepted pair.
    always @(negedge clk_i) begin
        if (reset_i && in_valid_i && in_ready[0]) begin
            exp_q[0].push_back(model(op_a_i, op_b_i, sub_op_i, rounding_mode_i, 1'b0));
            exp_q[1].push_back(model(op_a_i, op_b_i, sub_op_i, rounding_mode_i, 1'b1));
        end
    end

    // Monitor: compare every output transfer against the queued expectation.
    always @(negedge clk_i) begin
        if (reset_i) begin
            check("handshake_match", {75'd0, in_ready[1], out_valid[1]},
                  {75'd0, in_ready[0], out_valid[0]});
            if (out_valid[0] && out_ready_i) begin
                emitted++;
                if (exp_q[0].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output actual=%h required=none", out_vec[0]);
                end else begin
                    check("data_noflush", out_vec[0], exp_q[0].pop_front());
                    check("data_flush", out_vec[1], exp_q[1].pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        in_valid_i      = 1'b1;
        op_a_i          = a;
        op_b_i          = b;
        sub_op_i        = 1'($urandom_range(0, 1));
        rounding_mode_i = 3'($urandom_range(0, 4));
    endtask

    task automatic drain();
        int n;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        n = 0;
        while ((exp_q[0].size() != 0 || out_valid[0]) && n < 50) begin
            step();
            n++;
        end
        check("drain_done", {76'd0, (exp_q[0].size() == 0 && !out_valid[0])}, 77'd1);
    endtask

    initial begin
        int base;
        // Reset state.
        #2;
        check("reset_ctrl", {75'd0, in_ready[0], out_valid[0]}, 77'd2);
        check("reset_data0", out_vec[0], 77'd0);
        check("reset_data1", out_vec[1], 77'd0);
        @(posedge clk_i);
        #1 reset_i = 1'b1;

        // Directed: normal pair, subnormal, NaN/Inf cases; one-cycle latency.
        out_ready_i = 1'b1;
        drive(32'h3F800000, 32'hC0000000);
        sub_op_i = 1'b1;
        step();
        check("latency_1", {76'd0, out_valid[0]}, 77'd1);
        drive(32'h00000001, 32'h80000000);
        step();
        drive(32'h7F800001, 32'hFF800000);
        step();
        drive(32'h7FC00000, 32'h00400000);
        step();
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) drive(rand_op(), rand_op());
            else in_valid_i = 1'b0;
            out_ready_i = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        // Backpressure: three pushes while the consumer stalls.
        base = emitted;
        out_ready_i = 1'b0;
        drive(rand_op(), rand_op());
        step();
        check("bp_ready_p1", {76'd0, in_ready[0]}, {76'd0, SKID});
        drive(rand_op(), rand_op());
        step();
        check("bp_ready_p2", {76'd0, in_ready[0]}, 77'd0);
        drive(rand_op(), rand_op());
        step();
        check("bp_ready_p3", {76'd0, in_ready[0]}, 77'd0);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        check("bp_ready_after_pop", {76'd0, in_ready[0]}, 77'd1);
        drain();
        check("bp_count", 77'(emitted - base), SKID ? 77'd2 : 77'd1);

        // Continuous push and pop from a one-entry state.
        out_ready_i = 1'b0;
        drive(rand_op(), rand_op());
        step();
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(rand_op(), rand_op());
            step();
            check("stream_valid", {75'd0, out_valid[0], in_ready[0]}, 77'd3);
        end
        drain();

        // Reset with held pairs: everything discarded, restart immediately.
        out_ready_i = 1'b0;
        drive(rand_op(), rand_op());
        step();
        drive(rand_op(), rand_op());
        step();
        in_valid_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        check("midreset_ctrl", {75'd0, in_ready[0], out_valid[0]}, 77'd2);
        check("midreset_data", out_vec[0], 77'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        step();
        reset_i     = 1'b1;
        out_ready_i = 1'b1;
        drive(32'h3F800000, 32'h7F800001);
        step();
        check("post_reset_accept", {76'd0, out_valid[0]}, 77'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
